// File: rtl/ad9643_regs_pkg.sv
// Shared definitions for the AD9643 SPI register model.
// Contents:
//   - default addresses of the command/export registers and their command bit indices
//   - walk_state_e : state encoding of the register-file walk FSM (idle / transfer / clear)
package ad9643_regs_pkg;

    localparam int unsigned XFER_ADDR_DEF   = 'hFF;  // transfer register
    localparam int unsigned XFER_BIT_DEF    = 0;     // master -> shadow copy command
    localparam int unsigned SRST_ADDR_DEF   = 'h00;  // SPI config register
    localparam int unsigned SRST_BIT_DEF    = 5;     // soft-reset command
    localparam int unsigned CLKDIV_ADDR_DEF = 'h0B;  // shadow exported as clock_divide

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_CLEAR = 2'd2
    } walk_state_e;

endpackage

// File: rtl/reg_file_shadow_if.sv
// Request/response port between the SPI slave (master side) and the register file (slave side).
// Signals:
//   req_valid/req_ready  handshake, accept = valid & ready
//   req_write            1 = write, 0 = read
//   req_addr/req_wdata   register address and write data
//   resp_valid           one-cycle pulse, one per accepted request
//   resp_rdata/resp_err  read data (0 for writes/errors), out-of-range flag
interface reg_file_shadow_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/reg_walk_ctr.sv
// Index counter for the register-file copy/clear walks.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   start         command accepted; walk begins at index 0
//   step          walk in progress; advance one index per cycle
//   idx           current walk index, 0..DEPTH-1
//   done          idx is the last register (DEPTH-1)
// The counter sits at 0 whenever no walk is running and never wraps past DEPTH-1.
module reg_walk_ctr #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic             done
);

    logic [IDX_W-1:0] idx_q, idx_d;

    assign done = (idx_q == IDX_W'(DEPTH - 1));
    assign idx  = idx_q;

    always_comb begin
        if (start || !step || done) idx_d = '0;
        else                        idx_d = idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use <= so every flop samples pre-edge values regardless of statement order.
        if (!reset_n) idx_q <= '0;
        else          idx_q <= idx_d;
    end

endmodule

// File: rtl/reg_file_shadow.sv
// Master/shadow register file for the AD9643 SPI model.
// The SPI slave writes masters through the request port; a transfer command copies every
// master into its shadow (one register per cycle), a soft-reset command clears both arrays.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bus            request/response port (slave modport)
//   clock_divide   shadow[CLKDIV_ADDR]
//   busy           copy/clear walk in progress (requests stalled)
module reg_file_shadow
    import ad9643_regs_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned XFER_ADDR   = XFER_ADDR_DEF,
    parameter int unsigned XFER_BIT    = XFER_BIT_DEF,
    parameter int unsigned SRST_ADDR   = SRST_ADDR_DEF,
    parameter int unsigned SRST_BIT    = SRST_BIT_DEF,
    parameter int unsigned CLKDIV_ADDR = CLKDIV_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    reg_file_shadow_if.slave  bus,
    output logic [DATA_W-1:0] clock_divide,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam idx_t  XFER_IDX   = idx_t'(XFER_ADDR);
    localparam idx_t  SRST_IDX   = idx_t'(SRST_ADDR);
    localparam idx_t  CLKDIV_IDX = idx_t'(CLKDIV_ADDR);
    localparam word_t XFER_MASK  = word_t'(1) << XFER_BIT;
    localparam word_t SRST_MASK  = word_t'(1) << SRST_BIT;

    walk_state_e state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    word_t       resp_rdata_q, resp_rdata_d;
    word_t       master_q [DEPTH];
    word_t       master_d [DEPTH];
    word_t       shadow_q [DEPTH];
    word_t       shadow_d [DEPTH];

    logic [ADDR_W-1:0] req_addr;
    idx_t              req_idx;
    idx_t              walk_idx;
    logic              walk_done;
    logic              walk_start;
    logic              accept;
    logic              in_range;

    assign req_addr = bus.req_addr;
    assign req_idx  = req_addr[IDX_W-1:0];
    assign in_range = 32'(req_addr) < 32'(DEPTH);
    assign accept   = bus.req_valid & req_ready_q;

    reg_walk_ctr #(.DEPTH(DEPTH)) u_walk_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (walk_start),
        .step    (state_q != ST_IDLE),
        .idx     (walk_idx),
        .done    (walk_done)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        master_d     = master_q;
        shadow_d     = shadow_q;
        walk_start   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    resp_valid_d = 1'b1;
                    if (!in_range) begin
                        resp_err_d = 1'b1;
                    end else if (bus.req_write) begin
                        master_d[req_idx] = bus.req_wdata;
                        // Soft reset wins if both commands could fire from one write.
                        if (req_idx == SRST_IDX && (bus.req_wdata & SRST_MASK) != '0) begin
                            state_d    = ST_CLEAR;
                            walk_start = 1'b1;
                        end else if (req_idx == XFER_IDX && (bus.req_wdata & XFER_MASK) != '0) begin
                            state_d    = ST_XFER;
                            walk_start = 1'b1;
                        end
                    end else begin
                        resp_rdata_d = master_q[req_idx];
                    end
                    if (walk_start) begin
                        req_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                // The shadow of XFER_ADDR takes the pre-clear value since it reads master_q.
                shadow_d[walk_idx] = master_q[walk_idx];
                if (walk_done) begin
                    master_d[XFER_IDX] = master_q[XFER_IDX] & ~XFER_MASK;
                    state_d            = ST_IDLE;
                    req_ready_d        = 1'b1;
                    busy_d             = 1'b0;
                end
            end
            ST_CLEAR: begin
                master_d[walk_idx] = '0;
                shadow_d[walk_idx] = '0;
                if (walk_done) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            // NOTE: the arrays are flops with async reset, not RAM, because reset must zero every register at once.
            master_q     <= '{default: '0};
            shadow_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            master_q     <= master_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign clock_divide   = shadow_q[CLKDIV_IDX];
    assign busy           = busy_q;

endmodule

// File: tb/tb_reg_file_shadow.sv
// Self-checking bench for reg_file_shadow: directed scenarios plus randomized traffic,
// compared against a register-level reference model (master/shadow arrays).
module tb_reg_file_shadow;

    localparam int DEPTH  = 256;
    localparam int CLKDIV = 'h0B;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] clock_divide;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] m [DEPTH];
    logic [7:0] s [DEPTH];

    reg_file_shadow_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    reg_file_shadow dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .clock_divide (clock_divide),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 8'h00;
            s[i] = 8'h00;
        end
    endtask

    // mode 0: normal; mode 1: hold a read of CLKDIV during any walk; mode 2: reset at walk cycle 100
    task automatic issue(input bit w, input int a, input int d, input int mode, input string tag);
        int         n;
        int         cnt;
        int         resp_seen;
        int         cmd;
        logic [7:0] exp_r;
        bit         exp_e;

        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = 13'(a);
        bus.req_wdata = 8'(d);
        n = 0;
        while (!bus.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);

        exp_e = (a >= DEPTH);
        exp_r = (!w && !exp_e) ? m[a] : 8'h00;
        cmd   = 0;
        if (w && !exp_e) begin
            m[a] = 8'(d);
            if (a == 'h00 && (d & 'h20) != 0)      cmd = 2;
            else if (a == 'hFF && (d & 'h01) != 0) cmd = 1;
        end
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_rdata"},      32'(bus.resp_rdata), 32'(exp_r));
        check({tag, "_err"},        32'(bus.resp_err),   32'(exp_e));

        if (mode == 1) begin
            bus.req_write = 1'b0;
            bus.req_addr  = 13'(CLKDIV);
        end else begin
            bus.req_valid = 1'b0;
        end

        if (cmd != 0) begin
            check({tag, "_busy_start"},  32'(busy),          32'd1);
            check({tag, "_ready_start"}, 32'(bus.req_ready), 32'd0);
            cnt       = 0;
            resp_seen = 0;
            while (busy && cnt < 2000 && !(mode == 2 && cnt == 100)) begin
                cnt++;
                @(negedge clk);
                if (bus.resp_valid) resp_seen++;
            end
            if (mode == 2) begin
                #2 reset_n = 1'b0;
                #1;
                check({tag, "_rst_busy"},   32'(busy),           32'd0);
                check({tag, "_rst_clkdiv"}, 32'(clock_divide),   32'd0);
                check({tag, "_rst_ready"},  32'(bus.req_ready),  32'd0);
                check({tag, "_rst_resp"},   32'(bus.resp_valid), 32'd0);
                model_reset();
                resp_seen = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (bus.resp_valid || busy) resp_seen++;
                end
                check({tag, "_rst_quiet"}, 32'(resp_seen), 32'd0);
                reset_n = 1'b1;
                check({tag, "_ready_before_edge"}, 32'(bus.req_ready), 32'd0);
                @(negedge clk);
                check({tag, "_ready_after_edge"}, 32'(bus.req_ready), 32'd1);
                return;
            end
            check({tag, "_busy_cycles"},   32'(cnt),           32'd256);
            check({tag, "_no_resp_walk"},  32'(resp_seen),     32'd0);
            check({tag, "_ready_after"},   32'(bus.req_ready), 32'd1);
            if (cmd == 1) begin
                for (int i = 0; i < DEPTH; i++) s[i] = m[i];
                m['hFF] = m['hFF] & 8'hFE;
            end else begin
                model_reset();
            end
            if (mode == 1) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, "_held_valid"}, 32'(bus.resp_valid), 32'd1);
                check({tag, "_held_rdata"}, 32'(bus.resp_rdata), 32'(m[CLKDIV]));
                check({tag, "_held_err"},   32'(bus.resp_err),   32'd0);
                bus.req_valid = 1'b0;
                @(negedge clk);
                check({tag, "_held_single"}, 32'(bus.resp_valid), 32'd0);
            end
        end
        check({tag, "_clkdiv"}, 32'(clock_divide), 32'(s[CLKDIV]));
    endtask

    initial begin
        int a;
        int d;
        bit w;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ready",  32'(bus.req_ready),  32'd0);
        check("reset_resp",   32'(bus.resp_valid), 32'd0);
        check("reset_busy",   32'(busy),           32'd0);
        check("reset_clkdiv", 32'(clock_divide),   32'd0);
        reset_n = 1'b1;
        check("ready_before_first_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_first_edge", 32'(bus.req_ready), 32'd1);

        issue(1'b0, 'h0B, 0, 0, "rd_0b_reset");
        issue(1'b1, 'h0B, 'h05, 0, "wr_0b_05");
        issue(1'b0, 'h0B, 0, 0, "rd_0b_05");
        issue(1'b1, 'hFF, 'h01, 0, "xfer1");
        issue(1'b0, 'hFF, 0, 0, "rd_ff_cleared");

        // Out of range
        issue(1'b1, 'h12C, 'hAA, 0, "wr_oob");
        issue(1'b0, 'h12C, 0, 0, "rd_oob");
        issue(1'b0, 'h1FFF, 0, 0, "rd_top_addr");

        // Transfer then soft reset
        issue(1'b1, 'h0B, 'h07, 0, "wr_0b_07");
        issue(1'b1, 'hFF, 'h01, 0, "xfer2");
        issue(1'b1, 'h00, 'h20, 0, "srst");
        issue(1'b0, 'h0B, 0, 0, "rd_0b_after_clr");
        issue(1'b0, 'h00, 0, 0, "rd_00_after_clr");
        issue(1'b0, 'hFF, 0, 0, "rd_ff_after_clr");

        // Request held during a transfer walk
        issue(1'b1, 'h0B, 'h33, 0, "wr_0b_33");
        issue(1'b1, 'hFF, 'h01, 1, "xfer_hold");

        // Randomized traffic with periodic transfers
        for (int k = 0; k < 40; k++) begin
            if (k % 10 == 9) begin
                issue(1'b1, 'hFF, 'h01, 0, "rand_xfer");
            end else begin
                a = int'($urandom_range(0, 'h12F));
                if (k % 4 == 0) a = CLKDIV;
                d = int'($urandom_range(0, 255));
                w = 1'($urandom_range(0, 1));
                if (w && a == 'h00) d = d & 'hDF;
                if (w && a == 'hFF) d = d & 'hFE;
                issue(w, a, d, 0, w ? "rand_wr" : "rand_rd");
            end
        end

        // Reset in the middle of a walk
        issue(1'b1, 'h0B, 'h5A, 0, "wr_0b_5a");
        issue(1'b1, 'hFF, 'h01, 0, "xfer3");
        issue(1'b1, 'h0B, 'h11, 0, "wr_0b_11");
        issue(1'b1, 'hFF, 'h01, 2, "xfer_abort");
        issue(1'b0, 'h0B, 0, 0, "rd_0b_post_abort");
        issue(1'b0, 'hFF, 0, 0, "rd_ff_post_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
